tick_seq: RTL and testbench
===========================

TICK_SEQ -- requirements
Module: tick_seq

Interface
REQ-001 SHALL have parameter DWC, default 8: prescaler counter width.
REQ-002 SHALL have parameter DWN, default 16: delay, period and pulse-count width.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port ctl_str, input, 1: start strobe.
REQ-006 SHALL have port ctl_stp, input, 1: stop strobe.
REQ-007 SHALL have port cfg_div, input, DWC: prescaler ratio - 1.
REQ-008 SHALL have port cfg_dly, input, DWN: delay, in ticks, before the first pulse.
REQ-009 SHALL have port cfg_per, input, DWN: pulse period in ticks, minus 1.
REQ-010 SHALL have port cfg_num, input, DWN: pulses per sequence; 0 means continuous.
REQ-011 SHALL have port trg, output, 1: output pulse, one clk cycle wide.
REQ-012 SHALL have port sts_bsy, output, 1: sequence active.
REQ-013 SHALL have port sts_don, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port sts_cnt, output, DWN: pulses issued in the current or last sequence.

Function
REQ-015 SHALL implement states IDLE, DLY and RUN; sts_bsy = (state != IDLE), registered.
REQ-016 SHALL, in IDLE with ctl_str=1 and ctl_stp=0:
- latch cfg_div, cfg_dly, cfg_per and cfg_num;
- clear the prescaler, sts_cnt and the delay counter (loaded with cfg_dly);
- enter DLY at the same edge.
REQ-017 SHALL use only the latched configuration while busy; cfg_* changes during DLY or RUN have no effect.
REQ-018 SHALL run the prescaler only in DLY or RUN:
- counter pc counts 0..div, then wraps to 0;
- tick = (pc == latched div), combinational;
- with div=0, tick is active in every busy cycle.
REQ-019 SHALL, in DLY on a tick:
- if the delay counter is 0, enter RUN with the period counter set to 0;
- otherwise decrement the delay counter.
REQ-020 SHALL, in RUN on a tick with the period counter at 0:
- register trg=1 for exactly one cycle;
- increment sts_cnt (wraps modulo 2^DWN);
- reload the period counter with the latched per.
REQ-021 SHALL, in RUN on a tick with the period counter nonzero, decrement the period counter.
REQ-022 SHALL, when num != 0 and the pulse of REQ-020 brings sts_cnt to num:
- at that same edge, enter IDLE and register sts_don=1 for one cycle;
- assert trg and sts_don in the same cycle.
REQ-023 SHALL, when num = 0, run until stopped; sts_cnt wraps with no other effect.
REQ-024 SHALL, on ctl_stp=1 in DLY or RUN:
- enter IDLE at the next edge;
- suppress any trg or sts_don due at that edge;
- leave sts_cnt holding its value.
REQ-025 SHALL ignore ctl_str while busy, and ignore ctl_str together with ctl_stp in IDLE.
REQ-026 SHALL hold sts_cnt after completion or stop until the next accepted start.
REQ-027 SHALL give trg and sts_don no combinational path from any input.

Reset
REQ-028 SHALL, while rst=1, force IDLE and set trg=0, sts_don=0, sts_bsy=0, sts_cnt=0; prescaler and latched config cleared to 0.
REQ-029 SHALL abort an active sequence immediately on reset assertion; no sts_don is produced.
REQ-030 SHALL accept ctl_str on the first clk edge after rst deasserts.

Verification
REQ-031 SHALL cover basic sequencing:
- stimulus: div=0, dly=0, per=1, num=3, start at edge E0;
- response: trg high after edges E2, E4, E6; sts_don high after E6; sts_bsy low after E6; sts_cnt=3.
REQ-032 SHALL cover prescale and delay:
- stimulus: div=3, dly=2, per=0, num=2, start at E0;
- response: ticks at E4, E8, E12, E16, E20; first trg after E16, second trg and sts_don after E20.
REQ-033 SHALL cover stop in continuous mode:
- stimulus: num=0, div=0, per=0, dly=0; ctl_stp after 5 trg pulses;
- response: no further trg, sts_don never high, sts_cnt=5, sts_bsy low after the next edge.
REQ-034 SHALL cover config and start during busy:
- stimulus: change cfg_per and pulse ctl_str during RUN;
- response: period unchanged, no restart, sts_cnt continues.
REQ-035 SHALL cover reset mid-operation:
- stimulus: assert rst asynchronously mid-RUN;
- response: all outputs 0 without a clock edge; a new start after release behaves as in REQ-031.
REQ-036 SHALL cover wrap:
- stimulus: DWN=4, num=0, run 17 pulses;
- response: sts_cnt reads 1, trg continues uninterrupted.

Source files
------------

// File: rtl/tick_seq_if.sv
// Control, configuration and status bundle for the tick_seq pulse sequencer.
// The master drives control/config and reads status; the slave is the sequencer.
interface tick_seq_if #(
  parameter int DWC = 8,
  parameter int DWN = 16
);
  logic           ctl_str;
  logic           ctl_stp;
  logic [DWC-1:0] cfg_div;
  logic [DWN-1:0] cfg_dly;
  logic [DWN-1:0] cfg_per;
  logic [DWN-1:0] cfg_num;
  logic           trg;
  logic           sts_bsy;
  logic           sts_don;
  logic [DWN-1:0] sts_cnt;

  modport master (
    output ctl_str, ctl_stp, cfg_div, cfg_dly, cfg_per, cfg_num,
    input  trg, sts_bsy, sts_don, sts_cnt
  );

  modport slave (
    input  ctl_str, ctl_stp, cfg_div, cfg_dly, cfg_per, cfg_num,
    output trg, sts_bsy, sts_don, sts_cnt
  );
endinterface

// File: rtl/tick_seq.sv
// Prescaled pulse sequencer: after a start it waits a delay, then emits a
// fixed number of one-cycle pulses (or runs continuously) at a set period.
module tick_seq #(
  parameter int DWC = 8,
  parameter int DWN = 16
) (
  input  logic     clk,
  input  logic     rst,
  tick_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DLY  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [DWC-1:0] pc_q, pc_d;
  logic [DWN-1:0] dcnt_q, dcnt_d;
  logic [DWN-1:0] pcnt_q, pcnt_d;
  logic [DWN-1:0] cnt_q, cnt_d;
  logic [DWN-1:0] cnt_inc;
  logic [DWC-1:0] div_q;
  logic [DWN-1:0] per_q;
  logic [DWN-1:0] num_q;
  logic           trg_q, trg_d;
  logic           don_q, don_d;
  logic           bsy_q;
  logic           load;
  logic           tick;

  assign tick    = (pc_q == div_q);
  assign cnt_inc = cnt_q + DWN'(1);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dcnt_d  = dcnt_q;
    pcnt_d  = pcnt_q;
    cnt_d   = cnt_q;
    trg_d   = 1'b0;
    don_d   = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.ctl_str && !bus.ctl_stp) begin
          state_d = DLY;
          load    = 1'b1;
          pc_d    = '0;
          cnt_d   = '0;
          dcnt_d  = bus.cfg_dly;
        end
      end

      DLY: begin
        if (bus.ctl_stp) begin
          state_d = IDLE;
        end else begin
          pc_d = tick ? '0 : pc_q + DWC'(1);
          if (tick) begin
            if (dcnt_q == '0) begin
              state_d = RUN;
              pcnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q - DWN'(1);
            end
          end
        end
      end

      RUN: begin
        // A stop wins over any pulse or completion falling on the same edge.
        if (bus.ctl_stp) begin
          state_d = IDLE;
        end else begin
          pc_d = tick ? '0 : pc_q + DWC'(1);
          if (tick) begin
            if (pcnt_q == '0) begin
              trg_d  = 1'b1;
              cnt_d  = cnt_inc;
              pcnt_d = per_q;
              if ((num_q != '0) && (cnt_inc == num_q)) begin
                state_d = IDLE;
                don_d   = 1'b1;
              end
            end else begin
              pcnt_d = pcnt_q - DWN'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      trg_q   <= 1'b0;
      don_q   <= 1'b0;
      bsy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      trg_q   <= trg_d;
      don_q   <= don_d;
      bsy_q   <= (state_d != IDLE);
    end
  end

  // Configuration is captured once at start and frozen for the whole sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      per_q <= '0;
      num_q <= '0;
    end else if (load) begin
      div_q <= bus.cfg_div;
      per_q <= bus.cfg_per;
      num_q <= bus.cfg_num;
    end
  end

  assign bus.trg     = trg_q;
  assign bus.sts_don = don_q;
  assign bus.sts_bsy = bsy_q;
  assign bus.sts_cnt = cnt_q;

endmodule

// File: tb/tb_tick_seq.sv
// Directed bench for tick_seq: a vector table for basic sequencing plus
// hand-written sequences for prescale, stop, busy-start, reset and wrap.
module tb_tick_seq;

  logic clk;
  logic rst;

  tick_seq_if #(.DWC(8), .DWN(16)) m ();
  tick_seq_if #(.DWC(8), .DWN(4))  w ();

  tick_seq #(.DWC(8), .DWN(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m)
  );

  tick_seq #(.DWC(8), .DWN(4)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        str;
    logic        stp;
    logic        exp_trg;
    logic        exp_don;
    logic        exp_bsy;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [11];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each row: inputs held before an edge, outputs expected just after it.
  task automatic run_table();
    for (int i = 0; i < 11; i++) begin
      m.ctl_str = tbl[i].str;
      m.ctl_stp = tbl[i].stp;
      step();
      check($sformatf("tbl[%0d].trg", i), 32'(m.trg),     32'(tbl[i].exp_trg));
      check($sformatf("tbl[%0d].don", i), 32'(m.sts_don), 32'(tbl[i].exp_don));
      check($sformatf("tbl[%0d].bsy", i), 32'(m.sts_bsy), 32'(tbl[i].exp_bsy));
      check($sformatf("tbl[%0d].cnt", i), 32'(m.sts_cnt), 32'(tbl[i].exp_cnt));
    end
    m.ctl_str = 1'b0;
    m.ctl_stp = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] div, input logic [15:0] dly,
                         input logic [15:0] per, input logic [15:0] num);
    m.cfg_div = div;
    m.cfg_dly = dly;
    m.cfg_per = per;
    m.cfg_num = num;
  endtask

  task automatic start_m();
    m.ctl_str = 1'b1;
    step();
    m.ctl_str = 1'b0;
  endtask

  int npulse;
  int ndon;

  initial begin
    // div=0, dly=0, per=1, num=3: pulses after E2, E4, E6; done with E6.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3};  // start+stop in IDLE ignored
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};  // new start clears count
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};  // stop during delay

    rst = 1'b1;
    m.ctl_str = 1'b0;
    m.ctl_stp = 1'b0;
    set_cfg(8'd0, 16'd0, 16'd0, 16'd0);
    w.ctl_str = 1'b0;
    w.ctl_stp = 1'b0;
    w.cfg_div = 8'd0;
    w.cfg_dly = 4'd0;
    w.cfg_per = 4'd0;
    w.cfg_num = 4'd0;

    #2;
    check("reset.trg", 32'(m.trg),     32'd0);
    check("reset.don", 32'(m.sts_don), 32'd0);
    check("reset.bsy", 32'(m.sts_bsy), 32'd0);
    check("reset.cnt", 32'(m.sts_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic sequencing, first start right after reset release.
    set_cfg(8'd0, 16'd0, 16'd1, 16'd3);
    run_table();

    // Prescale and delay: ticks at E4..E20, pulses after E16 and E20.
    set_cfg(8'd3, 16'd2, 16'd0, 16'd2);
    start_m();
    check("pd.bsy0", 32'(m.sts_bsy), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("pd.trg@E%0d", k), 32'(m.trg),     32'((k == 16) || (k == 20)));
      check($sformatf("pd.don@E%0d", k), 32'(m.sts_don), 32'(k == 20));
    end
    check("pd.bsy_end", 32'(m.sts_bsy), 32'd0);
    check("pd.cnt_end", 32'(m.sts_cnt), 32'd2);

    // Stop in continuous mode after five pulses.
    set_cfg(8'd0, 16'd0, 16'd0, 16'd0);
    start_m();
    npulse = 0;
    ndon   = 0;
    for (int k = 0; k < 50 && npulse < 5; k++) begin
      step();
      if (m.trg) npulse++;
      if (m.sts_don) ndon++;
    end
    check("stp.pulses_seen", 32'(npulse), 32'd5);
    m.ctl_stp = 1'b1;
    step();
    m.ctl_stp = 1'b0;
    check("stp.trg", 32'(m.trg),     32'd0);
    check("stp.bsy", 32'(m.sts_bsy), 32'd0);
    check("stp.cnt", 32'(m.sts_cnt), 32'd5);
    npulse = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (m.trg) npulse++;
      if (m.sts_don) ndon++;
    end
    check("stp.trg_after", 32'(npulse), 32'd0);
    check("stp.don_never", 32'(ndon),   32'd0);
    check("stp.cnt_held",  32'(m.sts_cnt), 32'd5);

    // Config change and start strobe during RUN: period 3 kept, count continues.
    set_cfg(8'd0, 16'd0, 16'd2, 16'd0);
    start_m();
    step();
    step();
    check("busy.trg@E2", 32'(m.trg),     32'd1);
    check("busy.cnt@E2", 32'(m.sts_cnt), 32'd1);
    m.cfg_per = 16'd0;
    m.ctl_str = 1'b1;
    for (int k = 3; k <= 10; k++) begin
      step();
      m.ctl_str = 1'b0;
      check($sformatf("busy.trg@E%0d", k), 32'(m.trg), 32'((k == 5) || (k == 8)));
    end
    check("busy.cnt_end", 32'(m.sts_cnt), 32'd3);
    check("busy.bsy_end", 32'(m.sts_bsy), 32'd1);
    m.ctl_stp = 1'b1;
    step();
    m.ctl_stp = 1'b0;
    check("busy.stopped", 32'(m.sts_bsy), 32'd0);

    // Asynchronous reset mid-RUN, then the basic sequence again.
    set_cfg(8'd0, 16'd0, 16'd1, 16'd3);
    start_m();
    step();
    step();
    check("rst.pre_trg", 32'(m.trg),     32'd1);
    check("rst.pre_cnt", 32'(m.sts_cnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst.async_trg", 32'(m.trg),     32'd0);
    check("rst.async_don", 32'(m.sts_don), 32'd0);
    check("rst.async_bsy", 32'(m.sts_bsy), 32'd0);
    check("rst.async_cnt", 32'(m.sts_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_table();

    // Wrap with a 4-bit count: 17 back-to-back pulses leave sts_cnt at 1.
    w.ctl_str = 1'b1;
    step();
    w.ctl_str = 1'b0;
    step();
    check("wrap.trg@E1", 32'(w.trg), 32'd0);
    for (int k = 2; k <= 18; k++) begin
      step();
      check($sformatf("wrap.trg@E%0d", k), 32'(w.trg), 32'd1);
    end
    check("wrap.cnt17", 32'(w.sts_cnt), 32'd1);
    step();
    check("wrap.trg_cont", 32'(w.trg),     32'd1);
    check("wrap.cnt18",    32'(w.sts_cnt), 32'd2);
    check("wrap.bsy",      32'(w.sts_bsy), 32'd1);
    w.ctl_stp = 1'b1;
    step();
    w.ctl_stp = 1'b0;
    check("wrap.stopped", 32'(w.sts_bsy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
